// File: rtl/bp_cce_lce_req_receiver_pkg.sv
// rtl/bp_cce_lce_req_receiver_pkg.sv - BedRock LCE request types, widths and beat-count helper
package bp_cce_lce_req_receiver_pkg;

  localparam int paddr_width_p     = 40;
  localparam int lce_id_width_p    = 4;
  localparam int cce_block_width_p = 512;
  localparam int data_width_p      = 64;
  localparam int max_beats_lp      = cce_block_width_p / data_width_p;
  localparam int lg_beats_lp       = $clog2(max_beats_lp + 1);

  typedef enum logic [3:0] {
    e_bedrock_req_rd_miss = 4'd0,
    e_bedrock_req_wr_miss = 4'd1,
    e_bedrock_req_uc_rd   = 4'd2,
    e_bedrock_req_uc_wr   = 4'd3
  } bp_bedrock_req_type_e;

  // bytes = 1 << size
  typedef enum logic [2:0] {
    e_bedrock_msg_size_1   = 3'd0,
    e_bedrock_msg_size_2   = 3'd1,
    e_bedrock_msg_size_4   = 3'd2,
    e_bedrock_msg_size_8   = 3'd3,
    e_bedrock_msg_size_16  = 3'd4,
    e_bedrock_msg_size_32  = 3'd5,
    e_bedrock_msg_size_64  = 3'd6,
    e_bedrock_msg_size_128 = 3'd7
  } bp_bedrock_msg_size_e;

  typedef struct packed {
    logic [lce_id_width_p-1:0] lce_id;
    logic [paddr_width_p-1:0]  addr;
    bp_bedrock_msg_size_e      size;
    bp_bedrock_req_type_e      msg_type;
  } bp_bedrock_lce_req_msg_header_s;

  localparam int lce_req_msg_header_width_lp = $bits(bp_bedrock_lce_req_msg_header_s);

  // Shared with uncached-store senders: at least one beat, never more than a block.
  function automatic logic [lg_beats_lp-1:0] bp_me_size_to_beats(input logic [2:0] size,
                                                                 input int data_width);
    int bytes;
    int beats;
    bytes = 1 << size;
    beats = bytes / (data_width / 8);
    if (beats < 1) beats = 1;
    if (beats > max_beats_lp) beats = max_beats_lp;
    return lg_beats_lp'(beats);
  endfunction

endpackage

// File: rtl/bp_cce_lce_req_receiver_if.sv
// rtl/bp_cce_lce_req_receiver_if.sv - LCE request burst channel plus assembled-record channel
interface bp_cce_lce_req_receiver_if;
  import bp_cce_lce_req_receiver_pkg::*;

  bp_bedrock_lce_req_msg_header_s lce_req_header;
  logic                           lce_req_header_v;
  logic                           lce_req_header_ready_and;
  logic [data_width_p-1:0]        lce_req_data;
  logic                           lce_req_data_v;
  logic                           lce_req_data_ready_and;
  logic                           lce_req_last;

  bp_bedrock_lce_req_msg_header_s req_header;
  logic [cce_block_width_p-1:0]   req_data;
  logic                           req_v;
  logic                           req_yumi;
  logic                           protocol_error;

  modport master (
    output lce_req_header, lce_req_header_v, lce_req_data, lce_req_data_v, lce_req_last, req_yumi,
    input  lce_req_header_ready_and, lce_req_data_ready_and, req_header, req_data, req_v,
           protocol_error
  );

  modport slave (
    input  lce_req_header, lce_req_header_v, lce_req_data, lce_req_data_v, lce_req_last, req_yumi,
    output lce_req_header_ready_and, lce_req_data_ready_and, req_header, req_data, req_v,
           protocol_error
  );
endinterface

// File: rtl/bp_cce_lce_req_receiver_counter.sv
// rtl/bp_cce_lce_req_receiver_counter.sv - clear/up beat counter, clear has priority
module bp_cce_lce_req_receiver_counter #(
  parameter int width_p = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               up,
  output logic [width_p-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        count <= '0;
    else if (clear) count <= '0;
    else if (up)    count <= count + width_p'(1);
  end

endmodule

// File: rtl/bp_cce_lce_req_receiver.sv
// rtl/bp_cce_lce_req_receiver.sv - assembles one LCE request (header + beats) into a record for the CCE
module bp_cce_lce_req_receiver
  import bp_cce_lce_req_receiver_pkg::*;
(
  input logic                    clk,
  input logic                    rst,
  bp_cce_lce_req_receiver_if.slave bus
);

  typedef enum logic [1:0] {e_ready, e_recv_data, e_issue} state_e;

  state_e                         state_r, state_n;
  bp_bedrock_lce_req_msg_header_s header_r;
  logic [cce_block_width_p-1:0]   data_r;
  logic [lg_beats_lp-1:0]         count;
  logic [lg_beats_lp-1:0]         expected_in, expected_r;
  logic                           header_accept, data_accept, err_set, error_r;

  assign expected_in = (bus.lce_req_header.msg_type == e_bedrock_req_uc_wr)
                     ? bp_me_size_to_beats(bus.lce_req_header.size, data_width_p)
                     : '0;
  assign expected_r  = (header_r.msg_type == e_bedrock_req_uc_wr)
                     ? bp_me_size_to_beats(header_r.size, data_width_p)
                     : '0;

  // Readies come from state alone so there is no valid->ready combinational path.
  assign bus.lce_req_header_ready_and = (state_r == e_ready);
  assign bus.lce_req_data_ready_and   = (state_r == e_recv_data);
  assign bus.req_v                    = (state_r == e_issue);
  assign bus.req_header               = header_r;
  assign bus.req_data                 = data_r;
  assign bus.protocol_error           = error_r;

  assign header_accept = bus.lce_req_header_v && (state_r == e_ready);
  assign data_accept   = bus.lce_req_data_v && (state_r == e_recv_data);

  bp_cce_lce_req_receiver_counter #(.width_p(lg_beats_lp)) beat_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (header_accept),
    .up    (data_accept),
    .count (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= e_ready;
    else     state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    err_set = 1'b0;
    case (state_r)
      e_ready: begin
        if (header_accept) begin
          if (expected_in == '0) begin
            state_n = e_issue;
            err_set = !bus.lce_req_last;
          end else begin
            state_n = e_recv_data;
          end
        end
      end
      e_recv_data: begin
        if (data_accept) begin
          if (count + lg_beats_lp'(1) == expected_r) begin
            state_n = e_issue;
            err_set = !bus.lce_req_last;
          end else if (bus.lce_req_last) begin
            // Early last: issue what arrived, missing beats stay zero.
            state_n = e_issue;
            err_set = 1'b1;
          end
        end
      end
      e_issue: begin
        if (bus.req_yumi) state_n = e_ready;
      end
      default: state_n = e_ready;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                header_r <= '0;
    else if (header_accept) header_r <= bus.lce_req_header;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r <= '0;
    end else if (header_accept) begin
      data_r <= '0;
    end else if (data_accept) begin
      for (int k = 0; k < max_beats_lp; k++) begin
        if (count == lg_beats_lp'(k)) data_r[k*data_width_p +: data_width_p] <= bus.lce_req_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          error_r <= 1'b0;
    else if (err_set) error_r <= 1'b1;
  end

  always @(negedge clk) begin
    assert (cce_block_width_p % data_width_p == 0);
    if (!rst) assert (!(bus.req_yumi && !bus.req_v));
  end

endmodule

// File: tb/tb_bp_cce_lce_req_receiver.sv
// tb/tb_bp_cce_lce_req_receiver.sv - directed bench for bp_cce_lce_req_receiver
module tb_bp_cce_lce_req_receiver;
  import bp_cce_lce_req_receiver_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  bp_cce_lce_req_receiver_if bus ();

  bp_cce_lce_req_receiver dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bp_bedrock_lce_req_msg_header_s mk_hdr(input bp_bedrock_req_type_e t,
                                                           input bp_bedrock_msg_size_e s,
                                                           input logic [39:0] a,
                                                           input logic [3:0] id);
    bp_bedrock_lce_req_msg_header_s h;
    h.msg_type = t;
    h.size     = s;
    h.addr     = a;
    h.lce_id   = id;
    return h;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_header(input bp_bedrock_lce_req_msg_header_s h, input logic last);
    int n = 0;
    bus.lce_req_header   = h;
    bus.lce_req_header_v = 1'b1;
    bus.lce_req_last     = last;
    while (!bus.lce_req_header_ready_and && n < 50) begin tick(); n++; end
    check_eq("header_ready_bound", 512'(n < 50), 512'(1));
    tick();
    bus.lce_req_header_v = 1'b0;
    bus.lce_req_last     = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic last, input int gap);
    int n = 0;
    repeat (gap) tick();
    bus.lce_req_data   = d;
    bus.lce_req_data_v = 1'b1;
    bus.lce_req_last   = last;
    while (!bus.lce_req_data_ready_and && n < 50) begin tick(); n++; end
    check_eq("data_ready_bound", 512'(n < 50), 512'(1));
    tick();
    bus.lce_req_data_v = 1'b0;
    bus.lce_req_last   = 1'b0;
  endtask

  task automatic consume();
    bus.req_yumi = 1'b1;
    tick();
    bus.req_yumi = 1'b0;
  endtask

  bp_bedrock_lce_req_msg_header_s h;
  logic [511:0] exp_blk;
  logic [63:0]  beat;
  int           gaps [8] = '{0, 2, 1, 0, 3, 0, 1, 2};
  int           acc_cyc [10];
  int           issued;

  initial begin
    bus.lce_req_header   = '0;
    bus.lce_req_header_v = 1'b0;
    bus.lce_req_data     = '0;
    bus.lce_req_data_v   = 1'b0;
    bus.lce_req_last     = 1'b0;
    bus.req_yumi         = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    check_eq("rst_req_v", 512'(bus.req_v), 512'(0));
    check_eq("rst_err", 512'(bus.protocol_error), 512'(0));
    check_eq("rst_readies", 512'({bus.lce_req_header_ready_and, bus.lce_req_data_ready_and}), 512'(2'b10));
    check_eq("rst_header", 512'(bus.req_header), 512'(0));

    // 1: stray beat in e_ready, then rd_miss header-only
    bus.lce_req_data   = 64'hBAD0_BAD0_BAD0_BAD0;
    bus.lce_req_data_v = 1'b1;
    tick();
    check_eq("stray_data_ready", 512'(bus.lce_req_data_ready_and), 512'(0));
    h = mk_hdr(e_bedrock_req_rd_miss, e_bedrock_msg_size_64, 40'h80_0000_0040, 4'd1);
    send_header(h, 1'b1);
    bus.lce_req_data_v = 1'b0;
    check_eq("t1_req_v", 512'(bus.req_v), 512'(1));
    check_eq("t1_header", 512'(bus.req_header), 512'(h));
    check_eq("t1_data", bus.req_data, 512'(0));
    check_eq("t1_err", 512'(bus.protocol_error), 512'(0));
    consume();
    check_eq("t1_after_yumi", 512'({bus.req_v, bus.lce_req_header_ready_and}), 512'(2'b01));

    // 2: uc_wr 8B, single beat
    h = mk_hdr(e_bedrock_req_uc_wr, e_bedrock_msg_size_8, 40'h00_1000_0008, 4'd2);
    send_header(h, 1'b0);
    check_eq("t2_data_ready", 512'({bus.req_v, bus.lce_req_data_ready_and}), 512'(2'b01));
    send_beat(64'hDEADBEEF_CAFEF00D, 1'b1, 0);
    check_eq("t2_req_v", 512'(bus.req_v), 512'(1));
    check_eq("t2_data", bus.req_data, 512'(64'hDEADBEEF_CAFEF00D));
    check_eq("t2_err", 512'(bus.protocol_error), 512'(0));
    consume();

    // 3: uc_wr 64B, 8 beats with gaps, then stall yumi for 5 cycles
    h = mk_hdr(e_bedrock_req_uc_wr, e_bedrock_msg_size_64, 40'h00_2000_0000, 4'd3);
    send_header(h, 1'b0);
    exp_blk = '0;
    for (int k = 0; k < 8; k++) begin
      beat = {32'h1111_0000 + 32'(k), 32'hA5A5_0000 | 32'(k * 3)};
      exp_blk[k*64 +: 64] = beat;
      send_beat(beat, k == 7, gaps[k]);
      if (k < 7) check_eq("t3_no_early_v", 512'(bus.req_v), 512'(0));
    end
    check_eq("t3_req_v", 512'(bus.req_v), 512'(1));
    check_eq("t3_err", 512'(bus.protocol_error), 512'(0));
    for (int c = 0; c < 5; c++) begin
      check_eq("t3_hold_data", bus.req_data, exp_blk);
      check_eq("t3_hold_hdr_v", 512'({bus.req_header, bus.req_v}), 512'({h, 1'b1}));
      check_eq("t3_hold_readies", 512'({bus.lce_req_header_ready_and, bus.lce_req_data_ready_and}), 512'(0));
      tick();
    end
    consume();

    // 4: uc_wr 32B with last on beat 2 -> error, beats 2,3 zero
    h = mk_hdr(e_bedrock_req_uc_wr, e_bedrock_msg_size_32, 40'h00_3000_0020, 4'd4);
    send_header(h, 1'b0);
    send_beat(64'h0123_4567_89AB_CDEF, 1'b0, 0);
    send_beat(64'hFEDC_BA98_7654_3210, 1'b1, 1);
    exp_blk = '0;
    exp_blk[63:0]   = 64'h0123_4567_89AB_CDEF;
    exp_blk[127:64] = 64'hFEDC_BA98_7654_3210;
    check_eq("t4_req_v", 512'(bus.req_v), 512'(1));
    check_eq("t4_err", 512'(bus.protocol_error), 512'(1));
    check_eq("t4_data", bus.req_data, exp_blk);
    consume();
    h = mk_hdr(e_bedrock_req_uc_rd, e_bedrock_msg_size_8, 40'h00_3000_0100, 4'd5);
    send_header(h, 1'b1);
    check_eq("t4_uc_rd_v", 512'({bus.req_v, bus.req_header}), 512'({1'b1, h}));
    check_eq("t4_err_sticky", 512'(bus.protocol_error), 512'(1));
    consume();

    // 5: async reset after beat 3 of 8
    h = mk_hdr(e_bedrock_req_uc_wr, e_bedrock_msg_size_64, 40'h00_4000_0000, 4'd6);
    send_header(h, 1'b0);
    for (int k = 0; k < 3; k++) send_beat(64'hC0DE_0000_0000_0000 | 64'(k + 1), 1'b0, 0);
    #2 rst = 1'b1;
    #1;
    check_eq("t5_async_v_err", 512'({bus.req_v, bus.protocol_error}), 512'(0));
    check_eq("t5_async_data", bus.req_data, 512'(0));
    check_eq("t5_async_hdr", 512'(bus.req_header), 512'(0));
    check_eq("t5_async_data_ready", 512'(bus.lce_req_data_ready_and), 512'(0));
    tick();
    rst = 1'b0;
    tick();
    h = mk_hdr(e_bedrock_req_rd_miss, e_bedrock_msg_size_64, 40'h00_5000_0040, 4'd7);
    send_header(h, 1'b1);
    check_eq("t5_next_v_hdr", 512'({bus.req_v, bus.req_header}), 512'({1'b1, h}));
    check_eq("t5_next_data_err", 512'({bus.req_data, bus.protocol_error}), 512'(0));
    consume();

    // 6: back-to-back uc_rd headers, yumi the same cycle as valid
    begin
      int i = 0;
      int cyc = 0;
      logic acc;
      issued = 0;
      bus.lce_req_last     = 1'b1;
      bus.lce_req_header   = mk_hdr(e_bedrock_req_uc_rd, e_bedrock_msg_size_8, 40'h00_6000_0000, 4'd0);
      bus.lce_req_header_v = 1'b1;
      while (i < 10 && cyc < 100) begin
        bus.req_yumi = bus.req_v;
        if (bus.req_v) begin
          check_eq("t6_order", 512'(bus.req_header.addr), 512'(40'h00_6000_0000 + 40'(issued * 64)));
          issued++;
        end
        acc = bus.lce_req_header_ready_and && bus.lce_req_header_v;
        tick();
        cyc++;
        if (acc) begin
          acc_cyc[i] = cyc;
          i++;
          bus.lce_req_header = mk_hdr(e_bedrock_req_uc_rd, e_bedrock_msg_size_8,
                                      40'h00_6000_0000 + 40'(i * 64), 4'(i));
          if (i == 10) bus.lce_req_header_v = 1'b0;
        end
      end
      bus.lce_req_last = 1'b0;
      check_eq("t6_bound", 512'(i), 512'(10));
      check_eq("t6_last_v", 512'(bus.req_v), 512'(1));
      check_eq("t6_last_hdr", 512'(bus.req_header.addr), 512'(40'h00_6000_0000 + 40'(9 * 64)));
      bus.req_yumi = 1'b1;
      tick();
      bus.req_yumi = 1'b0;
      issued++;
      check_eq("t6_issued", 512'(issued), 512'(10));
      for (int k = 1; k < 10; k++) check_eq("t6_spacing", 512'(acc_cyc[k] - acc_cyc[k-1]), 512'(2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
